// File: rtl/prgrom_pkg.sv
// Shared types for the program ROM loader.
// ST_CHK exists only when PRGROM_CHECKSUM_EN is defined.
package prgrom_pkg;

    localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_LOAD = 2'd1,
        ST_FIN  = 2'd2
`ifdef PRGROM_CHECKSUM_EN
        ,
        ST_CHK  = 2'd3
`endif
    } state_e;

    function automatic logic [31:0] put_lane(
        input logic [31:0] word,
        input logic [1:0]  lane,
        input logic [7:0]  data
    );
        logic [31:0] res;
        res = word;
        res[{lane, 3'b000} +: 8] = data;
        return res;
    endfunction

endpackage

// File: rtl/prgrom_ram.sv
// Single-port synchronous RAM, 32-bit words, registered read.
// A write takes priority over a read on the shared address.
module prgrom_ram #(
    parameter int ADDR_W = 14
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o
);

    logic [31:0] mem_q [0:(1 << ADDR_W) - 1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prgrom_loader.sv
// Program ROM with an in-field byte-stream loader.
// Define PRGROM_CHECKSUM_EN to add a trailing checksum byte check.
module prgrom_loader
    import prgrom_pkg::*;
#(
    parameter int          ADDR_W    = 14,
    parameter logic [31:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic              rom_clk_i,
    input  logic              rom_rst_i,
    input  logic [ADDR_W+1:0] rom_adr_i,
    output logic [31:0]       instr_o,
    output logic              instr_vld_o,
    input  logic              upg_start_i,
    input  logic [ADDR_W:0]   upg_len_i,
    input  logic              upg_byte_vld_i,
    input  logic [7:0]        upg_byte_i,
    output logic              upg_rdy_o,
    output logic              upg_done_o,
    output logic              upg_err_o,
    output logic              busy_o
);

    localparam logic [ADDR_W:0] DEPTH   = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] WC_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [31:0]       word_buf_q, word_buf_d;
    logic              rdy_q, rdy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              vld_q, vld_d;
`ifdef PRGROM_CHECKSUM_EN
    logic [7:0]        sum_q, sum_d;
`endif

    logic              start_ok;
    logic              take;
    logic              restart;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              unused_adr;

    assign start_ok   = (upg_len_i != '0) && (upg_len_i <= DEPTH);
    assign take       = upg_byte_vld_i && rdy_q;
    assign restart    = upg_start_i && (state_q != ST_FIN);
    assign unused_adr = ^rom_adr_i[1:0];

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        word_buf_d = word_buf_q;
        done_d     = done_q;
        err_d      = err_q;
`ifdef PRGROM_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        ram_we     = 1'b0;
        ram_wdata  = put_lane(word_buf_q, byte_cnt_q, upg_byte_i);

        if (restart) begin
            if (start_ok) begin
                done_d     = 1'b0;
                err_d      = 1'b0;
                byte_cnt_d = '0;
                word_cnt_d = '0;
                len_d      = upg_len_i;
`ifdef PRGROM_CHECKSUM_EN
                sum_d      = '0;
`endif
                state_d    = ST_LOAD;
            end else begin
                err_d   = 1'b1;
                state_d = ST_RUN;
            end
        end else begin
            unique case (state_q)
                ST_LOAD: begin
                    if (take) begin
                        word_buf_d = ram_wdata;
                        byte_cnt_d = byte_cnt_q + 2'd1;
`ifdef PRGROM_CHECKSUM_EN
                        sum_d      = sum_q + upg_byte_i;
`endif
                        if (byte_cnt_q == 2'd3) begin
                            ram_we     = 1'b1;
                            word_cnt_d = word_cnt_q + WC_ONE;
                            if (word_cnt_d == len_q) begin
`ifdef PRGROM_CHECKSUM_EN
                                state_d = ST_CHK;
`else
                                state_d = ST_FIN;
`endif
                            end
                        end
                    end
                end
`ifdef PRGROM_CHECKSUM_EN
                ST_CHK: begin
                    if (take) begin
                        if (8'(sum_q + upg_byte_i) == 8'd0) begin
                            state_d = ST_FIN;
                        end else begin
                            err_d   = 1'b1;
                            state_d = ST_RUN;
                        end
                    end
                end
`endif
                ST_FIN: begin
                    done_d  = 1'b1;
                    state_d = ST_RUN;
                end
                default: ;
            endcase
        end

        rdy_d  = (state_d == ST_LOAD);
`ifdef PRGROM_CHECKSUM_EN
        rdy_d  = rdy_d || (state_d == ST_CHK);
`endif
        busy_d = (state_d != ST_RUN);
        // Valid only after a full RUN cycle, i.e. a read was issued.
        vld_d  = (state_q == ST_RUN) && (state_d == ST_RUN);
    end

    always_ff @(posedge rom_clk_i) begin
        if (rom_rst_i) begin
            state_q    <= ST_RUN;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            word_buf_q <= '0;
            rdy_q      <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            vld_q      <= 1'b0;
`ifdef PRGROM_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            word_buf_q <= word_buf_d;
            rdy_q      <= rdy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            vld_q      <= vld_d;
`ifdef PRGROM_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign ram_re   = (state_q == ST_RUN);
    assign ram_addr = ram_we ? word_cnt_q[ADDR_W-1:0]
                             : rom_adr_i[ADDR_W+1:2];

    prgrom_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (rom_clk_i),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign instr_o     = vld_q ? ram_rdata : NOP_INSTR;
    assign instr_vld_o = vld_q;
    assign upg_rdy_o   = rdy_q;
    assign upg_done_o  = done_q;
    assign upg_err_o   = err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_prgrom_loader.sv
// Bench for prgrom_loader: per-cycle reference model plus directed checks.
// Set PRGROM_CHECKSUM_EN on both RTL and bench to cover the checksum byte.
module tb_prgrom_loader;

    localparam int          AW    = 14;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] NOP   = 32'h0000_0000;
`ifdef PRGROM_CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [AW+1:0] adr;
    logic [31:0]   instr;
    logic          vld;
    logic          start;
    logic [AW:0]   len;
    logic          bvld;
    logic [7:0]    b;
    logic          rdy;
    logic          done;
    logic          err;
    logic          busy;

    always #5 clk = ~clk;

    prgrom_loader #(
        .ADDR_W    (AW),
        .NOP_INSTR (NOP)
    ) dut (
        .rom_clk_i      (clk),
        .rom_rst_i      (rst),
        .rom_adr_i      (adr),
        .instr_o        (instr),
        .instr_vld_o    (vld),
        .upg_start_i    (start),
        .upg_len_i      (len),
        .upg_byte_vld_i (bvld),
        .upg_byte_i     (b),
        .upg_rdy_o      (rdy),
        .upg_done_o     (done),
        .upg_err_o      (err),
        .busy_o         (busy)
    );

    int checks = 0;
    int errors = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: phase 0=run 1=load 2=fin 3=chk
    logic [31:0] mm [int];
    int          m_phase = 0;
    bit          m_done, m_err, m_vld, m_known;
    logic [31:0] m_instr;
    logic [7:0]  m_bytes [$];
    int          m_widx, m_len;
    logic [7:0]  m_sum;
    bit          armed = 1'b0;

    always @(posedge clk) begin
        int old;
        int a;
        old = m_phase;
        a   = int'(adr >> 2);
        if (rst) begin
            m_phase = 0;
            m_done  = 0;
            m_err   = 0;
            m_vld   = 0;
            m_instr = NOP;
            m_known = 1;
            m_bytes.delete();
            armed   = 1'b1;
        end else begin
            if (start && old != 2) begin
                if (len == 0 || int'(len) > DEPTH) begin
                    m_err   = 1;
                    m_phase = 0;
                end else begin
                    m_done  = 0;
                    m_err   = 0;
                    m_bytes.delete();
                    m_widx  = 0;
                    m_len   = int'(len);
                    m_sum   = 8'd0;
                    m_phase = 1;
                end
            end else if (old == 1 && bvld) begin
                m_bytes.push_back(b);
                m_sum = m_sum + b;
                if (m_bytes.size() == 4) begin
                    mm[m_widx] = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                    m_widx++;
                    m_bytes.delete();
                    if (m_widx == m_len) m_phase = CHK_ON ? 3 : 2;
                end
            end else if (old == 3 && bvld) begin
                if (8'(m_sum + b) == 8'd0) begin
                    m_phase = 2;
                end else begin
                    m_err   = 1;
                    m_phase = 0;
                end
            end else if (old == 2) begin
                m_done  = 1;
                m_phase = 0;
            end
            if (old == 0 && m_phase == 0) begin
                m_vld   = 1;
                m_known = mm.exists(a);
                m_instr = m_known ? mm[a] : 32'hx;
            end else begin
                m_vld   = 0;
                m_instr = NOP;
                m_known = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("m_busy", 32'(busy), 32'(m_phase != 0));
            check("m_rdy", 32'(rdy), 32'(m_phase == 1 || m_phase == 3));
            check("m_done", 32'(done), 32'(m_done));
            check("m_err", 32'(err), 32'(m_err));
            check("m_vld", 32'(vld), 32'(m_vld));
            if (m_known) check("m_instr", instr, m_instr);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input int n);
        start = 1'b1;
        len   = n[AW:0];
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input bit gaps);
        int guard;
        guard = 0;
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        bvld = 1'b1;
        b    = v;
        while (!rdy && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check("rdy_timeout", 32'(rdy), 32'd1);
        tick();
        bvld = 1'b0;
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 20) begin
            tick();
            guard++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    logic [31:0] wq [$];

    task automatic load_words(input bit gaps);
        logic [7:0] s;
        s = 8'd0;
        start_load(wq.size());
        foreach (wq[i]) begin
            for (int k = 0; k < 4; k++) begin
                send(wq[i][8*k +: 8], gaps);
                s = s + wq[i][8*k +: 8];
            end
        end
        if (CHK_ON) send(~s + 8'd1, gaps);
        wait_idle();
    endtask

    task automatic fetch_chk(string name, input logic [AW+1:0] a, input logic [31:0] exp);
        adr = a;
        tick();
        @(negedge clk);
        check(name, instr, exp);
        check({name, "_vld"}, 32'(vld), 32'd1);
    endtask

    task automatic reset_vals(string name);
        check({name, "_instr"}, instr, NOP);
        check({name, "_vld"}, 32'(vld), 32'd0);
        check({name, "_rdy"}, 32'(rdy), 32'd0);
        check({name, "_done"}, 32'(done), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        len   = '0;
        bvld  = 1'b0;
        b     = 8'h00;
        adr   = '0;
        tick();
        tick();
        @(negedge clk);
        reset_vals("reset");
        rst = 1'b0;
        tick();

        // Preload six words, word 5 = DEADBEEF
        wq.delete();
        for (int i = 0; i < 6; i++)
            wq.push_back(i == 5 ? 32'hDEAD_BEEF : (32'hA5A5_0000 | 32'(i)));
        load_words(1'b0);
        fetch_chk("fetch_0x14", 16'h0014, 32'hDEAD_BEEF);
        fetch_chk("fetch_0x17", 16'h0017, 32'hDEAD_BEEF);

        // Two-word load from bytes 11..88
        wq.delete();
        wq.push_back(32'h4433_2211);
        wq.push_back(32'h8877_6655);
        load_words(1'b0);
        @(negedge clk);
        check("len2_done", 32'(done), 32'd1);
        check("len2_busy", 32'(busy), 32'd0);
        fetch_chk("len2_w0", 16'h0000, 32'h4433_2211);
        fetch_chk("len2_w1", 16'h0004, 32'h8877_6655);
        fetch_chk("len2_w5_kept", 16'h0014, 32'hDEAD_BEEF);

        // Illegal lengths
        start_load(DEPTH + 1);
        @(negedge clk);
        check("len_big_err", 32'(err), 32'd1);
        check("len_big_busy", 32'(busy), 32'd0);
        check("len_big_vld", 32'(vld), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        check("err_cleared", 32'(err), 32'd0);
        start_load(0);
        @(negedge clk);
        check("len0_err", 32'(err), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_vld", 32'(vld), 32'd1);

        // Reset after six bytes of a two-word load
        start_load(2);
        for (int i = 0; i < 6; i++) send(8'hA1 + 8'(i), 1'b0);
        rst = 1'b1;
        tick();
        @(negedge clk);
        reset_vals("mid_rst");
        rst = 1'b0;
        tick();
        fetch_chk("mid_rst_w0", 16'h0000, 32'hA4A3_A2A1);
        fetch_chk("mid_rst_w1", 16'h0004, 32'h8877_6655);

        // Bytes while not ready are dropped
        bvld = 1'b1;
        b    = 8'h5A;
        repeat (3) tick();
        bvld = 1'b0;
        fetch_chk("idle_bytes_w0", 16'h0000, 32'hA4A3_A2A1);

        // Gappy load aborted by a second start
        start_load(3);
        for (int i = 0; i < 5; i++) send(8'hB0 + 8'(i), 1'b1);
        wq.delete();
        wq.push_back(32'hC3C2_C1C0);
        wq.push_back(32'hC7C6_C5C4);
        load_words(1'b1);
        @(negedge clk);
        check("restart_done", 32'(done), 32'd1);
        fetch_chk("restart_w0", 16'h0000, 32'hC3C2_C1C0);
        fetch_chk("restart_w1", 16'h0004, 32'hC7C6_C5C4);
        fetch_chk("restart_w2", 16'h0008, 32'hA5A5_0002);

`ifdef PRGROM_CHECKSUM_EN
        start_load(1);
        send(8'h01, 1'b0);
        repeat (3) send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        wait_idle();
        @(negedge clk);
        check("cks_ok_done", 32'(done), 32'd1);
        check("cks_ok_err", 32'(err), 32'd0);
        start_load(1);
        send(8'h01, 1'b0);
        repeat (3) send(8'h00, 1'b0);
        send(8'hFE, 1'b0);
        wait_idle();
        @(negedge clk);
        check("cks_bad_done", 32'(done), 32'd0);
        check("cks_bad_err", 32'(err), 32'd1);
`endif

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
